shift_pipe_arb: RTL and testbench
=================================

Name: shift_pipe_arb

Overview:
- Shares one fixed-latency, non-stallable shift pipeline among num_req_p requesters.
- Arbitration is round-robin.
- Each requester has its own credit counter. The counter tracks free slots in that requester's downstream result buffer, so the pipeline never emits a result that cannot be accepted.
- The block contains the pipeline stages. Each result leaves with the id of the requester that issued it.

Parameters:
- width_p, 32: payload width in bits.
- stages_p, 4: pipeline latency in cycles; must be >= 1.
- num_req_p, 4: number of requesters; must be >= 2.
- credits_p, 2: initial and maximum credits per requester; must be >= 1.

Ports:
- clk  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- valid_i  in  num_req_p  per-requester request valid.
- data_i  in  num_req_p*width_p  per-requester payload; requester n occupies bits [n*width_p +: width_p].
- ready_o  out  num_req_p  per-requester grant (one-hot or zero).
- credit_return_i  in  num_req_p  one pulse per result slot freed downstream.
- valid_o  out  1  pipeline output valid.
- data_o  out  width_p  pipeline output payload.
- id_o  out  clog2(num_req_p)  requester id of the output.
- credits_o  out  num_req_p*clog2(credits_p+1)  current credit counts.
- err_o  out  1  sticky credit-overflow error.

Behaviour:
- Reset: one clock; reset_i is asynchronous and active-high.
  - Asserting reset_i immediately clears: all pipeline stages (valid, id, data), the round-robin pointer (last_r = num_req_p-1, so requester 0 has top priority first), err_o, and the perf counters.
  - Every credit counter is set to credits_p.
  - Outputs during and after reset: valid_o=0, data_o=0, id_o=0, ready_o=0, credits_o all = credits_p.
  - Reset mid-operation discards all in-flight results and restores full credits. No results appear after reset deassertion until new grants occur.
- Eligibility: requester n is eligible when valid_i[n]=1 and credit[n] > 0.
- Arbitration: combinational.
  - Among eligible requesters, the first one found searching upward from last_r+1, with wrap-around modulo num_req_p, is granted.
  - ready_o is one-hot for that requester, or all zero if nobody is eligible.
  - ready_o may depend combinationally on valid_i. Requesters must not make valid_i depend on ready_o.
- Transfer: a transfer happens when valid_i[n] & ready_o[n]. On that clock edge:
  - stage 0 loads {1, n, data_n};
  - last_r <= n;
  - credit[n] decrements, unless it also increments that cycle (see credits).
- No grant: stage 0 loads valid=0; its data and id hold their previous values (don't-care).
- Pipeline: shifts every cycle unconditionally, with no stall.
  - A grant in cycle t gives valid_o=1 in cycle t+stages_p, with the matching data and id.
  - Throughput: one result per cycle.
  - With stages_p=1, stage 0 drives the outputs directly.
- Credits:
  - credit_return_i[n] increments credit[n].
  - A simultaneous grant and return on n leaves credit[n] unchanged.
  - A return while credit[n]==credits_p with no grant on n is an overflow: the counter saturates at credits_p and err_o sets to 1 and stays set until reset.
  - At credit[n]==0, requester n is masked and ready_o[n]=0, even if valid_i[n]=1.
- Fairness: a continuously eligible requester is granted within num_req_p cycles.

Optional Feature:
- Macro: SHIFT_PIPE_ARB_PERF_EN.
- When defined, the block adds two outputs:
  - grant_cnt_o (num_req_p*32): per-requester count of transfers.
  - stall_cnt_o (num_req_p*32): per-requester count of cycles with valid_i[n]=1 and ready_o[n]=0.
- Both counters clear on reset and wrap at 2^32.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: reset, then valid_i=4'b0001, data0=0xA5A5_0001 for one cycle at t=10, stages_p=4 -> ready_o[0]=1 at t=10; valid_o=1, data_o=0xA5A5_0001, id_o=0 at t=14 only; credits_o[0]=1 from t=11.
- Round-robin: valid_i=4'b1111 held for 8 cycles, credit_return_i driven back after each result, credits_p=2 -> grant order 0,1,2,3,0,1,2,3; valid_o high 8 consecutive cycles with id_o in the same order.
- Credit exhaustion: requester 2 alone holds valid for 5 cycles with no returns, credits_p=2 -> exactly 2 grants; ready_o[2]=0 thereafter. One return pulse -> one more grant the next cycle.
- Simultaneous grant and return on requester 1 at credit=1 -> credit stays 1; ready_o[1] keeps granting each cycle while returns continue.
- Overflow: credit_return_i[3]=1 at full credit -> err_o=1 next cycle, credits_o[3] stays 2, err_o remains 1 until reset.
- Async reset mid-flight: reset_i asserted between clock edges while 3 results are in flight -> valid_o=0 immediately without a clock edge; all credits = credits_p; no result appears after reset deasserts.

Source files
------------

// File: rtl/shift_pipe_arb.sv
// Round-robin arbiter feeding a fixed-latency, non-stallable shift pipeline with per-requester
// credits. Optional perf counters are enabled by defining SHIFT_PIPE_ARB_PERF_EN.
module shift_pipe_arb #(
  parameter int unsigned width_p   = 32,
  parameter int unsigned stages_p  = 4,
  parameter int unsigned num_req_p = 4,
  parameter int unsigned credits_p = 2
) (
  input  logic                                       clk,
  input  logic                                       reset_i,
  input  logic [num_req_p-1:0]                       valid_i,
  input  logic [num_req_p*width_p-1:0]               data_i,
  output logic [num_req_p-1:0]                       ready_o,
  input  logic [num_req_p-1:0]                       credit_return_i,
  output logic                                       valid_o,
  output logic [width_p-1:0]                         data_o,
  output logic [$clog2(num_req_p)-1:0]               id_o,
  output logic [num_req_p*$clog2(credits_p+1)-1:0]   credits_o,
  output logic                                       err_o
`ifdef SHIFT_PIPE_ARB_PERF_EN
  ,
  output logic [num_req_p*32-1:0]                    grant_cnt_o,
  output logic [num_req_p*32-1:0]                    stall_cnt_o
`endif
);

  localparam int unsigned IdW  = $clog2(num_req_p);
  localparam int unsigned CntW = $clog2(credits_p + 1);
  localparam logic [CntW-1:0] CreditMax = CntW'(credits_p);
  localparam logic [IdW-1:0]  LastInit  = IdW'(num_req_p - 1);

  logic [IdW-1:0]     last_q;
  logic [CntW-1:0]    credit_q [num_req_p];
  logic [CntW-1:0]    credit_d [num_req_p];
  logic               err_q;
  logic               overflow;

  logic [num_req_p-1:0] eligible;
  logic [num_req_p-1:0] grant;
  logic                 grant_any;
  logic [IdW-1:0]       grant_id;
  logic [width_p-1:0]   grant_data;
  int unsigned          cand;

  logic [stages_p-1:0]  pipe_valid_q;
  logic [IdW-1:0]       pipe_id_q   [stages_p];
  logic [width_p-1:0]   pipe_data_q [stages_p];

  // Reset also masks eligibility so ready_o stays low while reset is held.
  always_comb begin
    eligible = '0;
    for (int unsigned n = 0; n < num_req_p; n++) begin
      eligible[n] = valid_i[n] && (credit_q[n] != '0) && !reset_i;
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= num_req_p; i++) begin
      cand = (32'(last_q) + i) % num_req_p;
      if (!grant_any && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_id    = IdW'(cand);
        grant_any   = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned n = 0; n < num_req_p; n++) begin
      if (grant[n]) grant_data = data_i[n*width_p +: width_p];
    end
  end

  assign ready_o = grant;

  // A grant and a return in the same cycle cancel; a lone return at full credit is an overflow.
  always_comb begin
    overflow = 1'b0;
    for (int unsigned n = 0; n < num_req_p; n++) begin
      credit_d[n] = credit_q[n];
      if (grant[n] && !credit_return_i[n]) begin
        credit_d[n] = credit_q[n] - CntW'(1);
      end else if (!grant[n] && credit_return_i[n]) begin
        if (credit_q[n] == CreditMax) overflow = 1'b1;
        else                          credit_d[n] = credit_q[n] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned n = 0; n < num_req_p; n++) credit_q[n] <= CreditMax;
      err_q <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < num_req_p; n++) credit_q[n] <= credit_d[n];
      err_q <= err_q | overflow;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      last_q       <= LastInit;
      pipe_valid_q <= '0;
      for (int unsigned s = 0; s < stages_p; s++) begin
        pipe_id_q[s]   <= '0;
        pipe_data_q[s] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= grant_any;
      if (grant_any) begin
        pipe_id_q[0]   <= grant_id;
        pipe_data_q[0] <= grant_data;
        last_q         <= grant_id;
      end
      for (int unsigned s = 1; s < stages_p; s++) begin
        pipe_valid_q[s] <= pipe_valid_q[s-1];
        pipe_id_q[s]    <= pipe_id_q[s-1];
        pipe_data_q[s]  <= pipe_data_q[s-1];
      end
    end
  end

  assign valid_o = pipe_valid_q[stages_p-1];
  assign id_o    = pipe_id_q[stages_p-1];
  assign data_o  = pipe_data_q[stages_p-1];
  assign err_o   = err_q;

  always_comb begin
    credits_o = '0;
    for (int unsigned n = 0; n < num_req_p; n++) begin
      credits_o[n*CntW +: CntW] = credit_q[n];
    end
  end

`ifdef SHIFT_PIPE_ARB_PERF_EN
  logic [31:0] grant_cnt_q [num_req_p];
  logic [31:0] stall_cnt_q [num_req_p];

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned n = 0; n < num_req_p; n++) begin
        grant_cnt_q[n] <= '0;
        stall_cnt_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < num_req_p; n++) begin
        if (grant[n])                grant_cnt_q[n] <= grant_cnt_q[n] + 32'd1;
        if (valid_i[n] && !grant[n]) stall_cnt_q[n] <= stall_cnt_q[n] + 32'd1;
      end
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    stall_cnt_o = '0;
    for (int unsigned n = 0; n < num_req_p; n++) begin
      grant_cnt_o[n*32 +: 32] = grant_cnt_q[n];
      stall_cnt_o[n*32 +: 32] = stall_cnt_q[n];
    end
  end
`endif

endmodule

// File: tb/tb_shift_pipe_arb.sv
// Scoreboard bench for shift_pipe_arb: stimulus pushes hand-computed results with their due
// cycle, a negedge monitor pops and compares whenever valid_o is high.
module tb_shift_pipe_arb;

  localparam int unsigned Stages = 4;

  logic         clk;
  logic         reset_i;
  logic [3:0]   valid_i;
  logic [127:0] data_i;
  logic [3:0]   ready_o;
  logic [3:0]   credit_return_i;
  logic         valid_o;
  logic [31:0]  data_o;
  logic [1:0]   id_o;
  logic [7:0]   credits_o;
  logic         err_o;

  shift_pipe_arb #(
    .width_p  (32),
    .stages_p (Stages),
    .num_req_p(4),
    .credits_p(2)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .credit_return_i(credit_return_i),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .id_o           (id_o),
    .credits_o      (credits_o),
    .err_o          (err_o)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] cr(input int n);
    return credits_o[n*2 +: 2];
  endfunction

  // Result is due Stages cycles after the grant cycle.
  task automatic push(input logic [1:0] id, input logic [31:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.cyc  = cyc + Stages;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got id=%0d data=%h, required no result (t=%0t)",
                 id_o, data_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_id", 64'(id_o), 64'(e.id));
        chk("out_data", 64'(data_o), 64'(e.data));
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_i = 1'b1;
    @(posedge clk);
    #2 reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    reset_i         = 1'b1;
    valid_i         = '0;
    data_i          = '0;
    credit_return_i = '0;

    #2 valid_i = 4'hF;
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_data_o", 64'(data_o), 64'd0);
    chk("rst_id_o", 64'(id_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd0);
    chk("rst_credits", 64'(credits_o), 64'hAA);
    chk("rst_err", 64'(err_o), 64'd0);
    valid_i = '0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    // Single request
    next_cycle();
    valid_i = 4'b0001;
    data_i[31:0] = 32'hA5A5_0001;
    @(negedge clk);
    chk("single_ready", 64'(ready_o), 64'b0001);
    push(2'd0, 32'hA5A5_0001);
    next_cycle();
    valid_i = '0;
    @(negedge clk);
    chk("single_credit0", 64'(cr(0)), 64'd1);
    wait_drain();
    next_cycle();
    credit_return_i = 4'b0001;
    next_cycle();
    credit_return_i = '0;
    @(negedge clk);
    chk("single_credit_back", 64'(cr(0)), 64'd2);

    // Round-robin from reset: 0,1,2,3,0,1,2,3 uses every credit
    do_reset();
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      valid_i = 4'hF;
      for (int n = 0; n < 4; n++) data_i[n*32 +: 32] = 32'hB000_0000 | (k << 8) | n;
      @(negedge clk);
      chk("rr_grant", 64'(ready_o), 64'(1 << (k % 4)));
      d = 32'hB000_0000 | (k << 8) | (k % 4);
      push(2'(k % 4), d);
    end
    next_cycle();
    @(negedge clk);
    chk("rr_all_masked", 64'(ready_o), 64'd0);
    chk("rr_credits_zero", 64'(credits_o), 64'h00);
    next_cycle();
    valid_i         = '0;
    credit_return_i = 4'hF;
    next_cycle();
    next_cycle();
    credit_return_i = '0;
    @(negedge clk);
    chk("rr_credits_back", 64'(credits_o), 64'hAA);
    wait_drain();

    // Credit exhaustion on requester 2
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      valid_i = 4'b0100;
      data_i[64 +: 32] = 32'hC000_0000 | k;
      @(negedge clk);
      chk("exh_ready", 64'(ready_o), (k < 2) ? 64'b0100 : 64'd0);
      if (k < 2) push(2'd2, 32'hC000_0000 | k);
    end
    next_cycle();
    credit_return_i = 4'b0100;
    data_i[64 +: 32] = 32'hC000_0005;
    @(negedge clk);
    chk("exh_ret_cycle", 64'(ready_o), 64'd0);
    next_cycle();
    credit_return_i = '0;
    data_i[64 +: 32] = 32'hC000_0006;
    @(negedge clk);
    chk("exh_regrant", 64'(ready_o), 64'b0100);
    push(2'd2, 32'hC000_0006);
    next_cycle();
    valid_i = '0;
    @(negedge clk);
    chk("exh_credit2", 64'(cr(2)), 64'd0);

    // Grant plus return on requester 1 at credit 1
    next_cycle();
    valid_i = 4'b0010;
    data_i[32 +: 32] = 32'hD000_0000;
    @(negedge clk);
    chk("sim_ready0", 64'(ready_o), 64'b0010);
    push(2'd1, 32'hD000_0000);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      credit_return_i = 4'b0010;
      data_i[32 +: 32] = 32'hD000_0000 | k;
      @(negedge clk);
      chk("sim_ready", 64'(ready_o), 64'b0010);
      chk("sim_credit1", 64'(cr(1)), 64'd1);
      push(2'd1, 32'hD000_0000 | k);
    end
    next_cycle();
    valid_i         = '0;
    credit_return_i = '0;
    @(negedge clk);
    chk("sim_credit1_hold", 64'(cr(1)), 64'd1);
    next_cycle();
    credit_return_i = 4'b0110;
    next_cycle();
    credit_return_i = 4'b0100;
    next_cycle();
    credit_return_i = '0;
    @(negedge clk);
    chk("restore_credits", 64'(credits_o), 64'hAA);
    chk("restore_err", 64'(err_o), 64'd0);
    wait_drain();

    // Overflow on requester 3
    next_cycle();
    credit_return_i = 4'b1000;
    @(negedge clk);
    chk("ovf_err_before", 64'(err_o), 64'd0);
    next_cycle();
    credit_return_i = '0;
    @(negedge clk);
    chk("ovf_err_set", 64'(err_o), 64'd1);
    chk("ovf_credit3", 64'(cr(3)), 64'd2);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("ovf_err_sticky", 64'(err_o), 64'd1);

    // Async reset with three results in flight; none are expected afterwards
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      valid_i = 4'hF;
      for (int n = 0; n < 4; n++) data_i[n*32 +: 32] = 32'hE000_0000 | n;
    end
    next_cycle();
    valid_i = '0;
    next_cycle();
    chk("pre_reset_valid", 64'(valid_o), 64'd1);
    #1 reset_i = 1'b1;
    valid_i = 4'hF;
    #1;
    chk("arst_valid_o", 64'(valid_o), 64'd0);
    chk("arst_data_o", 64'(data_o), 64'd0);
    chk("arst_id_o", 64'(id_o), 64'd0);
    chk("arst_ready_o", 64'(ready_o), 64'd0);
    chk("arst_credits", 64'(credits_o), 64'hAA);
    chk("arst_err", 64'(err_o), 64'd0);
    valid_i = '0;
    @(posedge clk);
    #2 reset_i = 1'b0;
    repeat (12) next_cycle();
    @(negedge clk);
    chk("post_reset_idle", 64'(valid_o), 64'd0);
    chk("post_reset_sb", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
